irq_stim_gen: RTL and testbench
===============================

Name: irq_stim_gen

Overview:
Parametrised multi-channel interrupt stimulus generator for the simulation top.
- Each channel raises its interrupt line after a runtime-programmable period.
- Two modes per channel: fixed-width pulse, or sticky level held until acknowledged.
- In level mode it counts periods that elapse without an acknowledge (overruns).
- With the default N_CH=3, channels 0/1/2 drive the core's sw_irq/timer_irq/ext_irq fields of s_irq_t; the top packs them.

Parameters:
N_CH, 3, number of independent interrupt channels (>=1)
CNT_W, 16, width of period and width counters/config fields
OVF_W, 4, width of per-channel saturating overrun counter
JIT_MASK, 16'h000F, jitter mask applied to LFSR value (used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
en_i  in  N_CH  per-channel enable, level
cfg_mode_i  in  N_CH  0 = pulse mode, 1 = sticky level mode
cfg_period_i  in  N_CH*CNT_W  per-channel period, channel c at [c*CNT_W +: CNT_W]; 0 = channel held off
cfg_width_i  in  N_CH*CNT_W  per-channel pulse width in cycles (pulse mode); 0 treated as 1
ack_i  in  N_CH  per-channel acknowledge, single-cycle pulse
irq_o  out  N_CH  registered interrupt lines
ovf_cnt_o  out  N_CH*OVF_W  per-channel saturating overrun count

Behaviour:
- Per-channel FSM with states OFF, COUNT, FIRE, HOLD.
- Per-channel registers: cnt (CNT_W), wcnt (CNT_W), ovf (OVF_W).
- Outputs are registered: irq_o[c] = 1 in FIRE or HOLD; ovf_cnt_o = ovf.
- Reset (rst=1 at a posedge): all channels go to OFF; cnt=0, wcnt=0, ovf=0; irq_o=0, ovf_cnt_o=0.
  - Reset has priority over every other event, including mid-FIRE and mid-HOLD.
- Any state, en_i[c]=0 or period==0 → OFF next edge: irq_o low, cnt=0, ovf=0.
- OFF → COUNT when en_i[c]=1 and period!=0; cnt<=0.
- COUNT:
  - If cnt==period-1: cnt<=0; enter FIRE if cfg_mode_i[c]=0, else HOLD. Mode is sampled only at this edge.
  - FIRE entry loads wcnt<=max(width,1).
  - Otherwise cnt<=cnt+1.
- Latency: irq_o[c] rises exactly `period` edges after the edge that sampled the OFF→COUNT transition.
- FIRE:
  - If wcnt==1 → COUNT, cnt<=0; else wcnt<=wcnt-1.
  - irq_o is high for max(width,1) cycles; rising-edge spacing = period + max(width,1) cycles.
- HOLD:
  - irq_o stays high; cnt keeps counting.
  - When cnt==period-1: cnt<=0 and ovf<=ovf+1, saturating at 2^OVF_W-1.
  - ack_i[c]=1 → COUNT, cnt<=0, ovf<=0. Ack wins over a simultaneous overrun increment.
  - irq_o drops on the edge after ack is sampled.
- ack_i in OFF/COUNT/FIRE: ignored, with no effect on state or ovf.
- cfg_period_i/cfg_width_i are read live:
  - A new period applies at the next compare.
  - If the new period-1 is below the current cnt, cnt counts up to 2^CNT_W-1, wraps to 0, then matches.
  - A new width applies at the next FIRE entry.
- Channels are fully independent; there is no arbitration between them.

Optional Feature:
Macro IRQ_STIM_JITTER_EN.
- Defined:
  - Each channel has a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1), seeded at reset to 16'hACE1 ^ c.
  - The compare value becomes period-1 + (lfsr & JIT_MASK), computed in CNT_W+1 bits so it does not wrap.
  - The LFSR advances one step on each COUNT→FIRE/HOLD transition and on each HOLD overrun.
- Undefined: no LFSR logic exists; compare is exactly period-1 and the timing is fully deterministic.

Test Plan:
1. Reset: rst=1 for 3 cycles with en_i all 1 → irq_o=0 and ovf_cnt_o=0 throughout; after release, ch0 (period=5, width=2, pulse) rises 5 edges after the first enable-sampling edge.
2. Pulse mode, ch1 period=4, width=3 → irq_o[1] high 3 cycles, low 4 cycles, repeating every 7 cycles for 10 repetitions; width=0 → exactly 1-cycle pulses every 5 cycles.
3. Level mode, ch2 period=8, no ack for 40 cycles → irq_o[2] held high; ovf_cnt_o reaches 4, and saturates at 15 after a further 100 cycles. Then ack pulse → irq_o[2] low next cycle, ovf=0, next rise 8 edges later.
4. Ack coincident with overrun compare in HOLD → ovf_cnt_o=0 and state COUNT; stray ack in COUNT/FIRE → no change.
5. Mid-operation disable: clear en_i[0] during FIRE → irq_o[0] low next edge. Re-enable with period=3 → first rise 3 edges later. Setting period=0 while enabled behaves like disable.
6. Independence: all 3 channels enabled with periods 3, 5, 7 in pulse mode, width 1 → each channel's edges match a per-channel reference model over 500 cycles; with IRQ_STIM_JITTER_EN, every inter-pulse gap lies in [period+1, period+1+15].

Source files
------------

// File: rtl/irq_stim_gen.sv
// irq_stim_gen: multi-channel interrupt stimulus generator.
// Each channel counts a programmable period and then raises its interrupt line.
// The line is either a pulse of programmable width or a sticky level that is
// held until acknowledged. While a level is pending, the channel counts
// unacknowledged periods (overruns) in a saturating counter.
// Optional feature macro: IRQ_STIM_JITTER_EN. It adds a per-channel 16-bit LFSR
// that stretches each period by (lfsr & JIT_MASK) cycles.
module irq_stim_gen #(
    parameter int          N_CH     = 3,
    parameter int          CNT_W    = 16,
    parameter int          OVF_W    = 4,
    parameter logic [15:0] JIT_MASK = 16'h000F
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         en_i,
    input  logic [N_CH-1:0]         cfg_mode_i,
    input  logic [N_CH*CNT_W-1:0]   cfg_period_i,
    input  logic [N_CH*CNT_W-1:0]   cfg_width_i,
    input  logic [N_CH-1:0]         ack_i,
    output logic [N_CH-1:0]         irq_o,
    output logic [N_CH*OVF_W-1:0]   ovf_cnt_o
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_COUNT = 2'd1,
        ST_FIRE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [OVF_W-1:0] OVF_ZERO = {OVF_W{1'b0}};
    localparam logic [OVF_W-1:0] OVF_ONE  = OVF_W'(1'b1);
    localparam logic [OVF_W-1:0] OVF_MAX  = {OVF_W{1'b1}};

    // Elaboration-time parameter sanity.
    if (N_CH < 1) begin : g_bad_n_ch
        $error("irq_stim_gen: N_CH must be at least 1");
    end
    if ((JIT_MASK >> CNT_W) != 16'h0000) begin : g_bad_jit_mask
        $error("irq_stim_gen: JIT_MASK has bits above the counter width");
    end

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [CNT_W-1:0] wcnt_q  [N_CH];
    logic [CNT_W-1:0] wcnt_d  [N_CH];
    logic [OVF_W-1:0] ovf_q   [N_CH];
    logic [OVF_W-1:0] ovf_d   [N_CH];
    logic [N_CH-1:0]  irq_q;
    logic [N_CH-1:0]  irq_d;

    logic [CNT_W-1:0] period_s    [N_CH];
    logic [CNT_W-1:0] width_eff_s [N_CH];
    logic [CNT_W:0]   cmp_s       [N_CH];
    logic [N_CH-1:0]  match_s;
    logic [N_CH-1:0]  live_s;

`ifdef IRQ_STIM_JITTER_EN
    logic [15:0]      lfsr_q [N_CH];
    logic [15:0]      lfsr_d [N_CH];
    logic [N_CH-1:0]  adv_s;

    // One Galois step of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign period_s[c]    = cfg_period_i[c*CNT_W +: CNT_W];
        // A zero width still produces a one-cycle pulse.
        assign width_eff_s[c] = (cfg_width_i[c*CNT_W +: CNT_W] == CNT_ZERO) ?
                                CNT_ONE : cfg_width_i[c*CNT_W +: CNT_W];
        assign live_s[c]      = en_i[c] && (period_s[c] != CNT_ZERO);
`ifdef IRQ_STIM_JITTER_EN
        // Extra bit keeps period-1+jitter from wrapping.
        assign cmp_s[c]   = {1'b0, period_s[c] - CNT_ONE} +
                            (CNT_W+1)'(lfsr_q[c] & JIT_MASK);
        // Advance on every COUNT exit to FIRE/HOLD and every HOLD overrun.
        assign adv_s[c]   = live_s[c] && match_s[c] &&
                            ((state_q[c] == ST_COUNT) ||
                             ((state_q[c] == ST_HOLD) && !ack_i[c]));
`else
        assign cmp_s[c]   = {1'b0, period_s[c] - CNT_ONE};
`endif
        assign match_s[c] = ({1'b0, cnt_q[c]} == cmp_s[c]);
        assign ovf_cnt_o[c*OVF_W +: OVF_W] = ovf_q[c];
    end

    assign irq_o = irq_q;

    // Per-channel next-state, counter updates and registered-output targets.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            wcnt_d[c]  = wcnt_q[c];
            ovf_d[c]   = ovf_q[c];
            if (!live_s[c]) begin
                state_d[c] = ST_OFF;
                cnt_d[c]   = CNT_ZERO;
                ovf_d[c]   = OVF_ZERO;
            end else begin
                case (state_q[c])
                    ST_OFF: begin
                        state_d[c] = ST_COUNT;
                        cnt_d[c]   = CNT_ZERO;
                    end
                    ST_COUNT: begin
                        if (match_s[c]) begin
                            cnt_d[c] = CNT_ZERO;
                            // Mode is only looked at on this edge.
                            if (cfg_mode_i[c]) begin
                                state_d[c] = ST_HOLD;
                            end else begin
                                state_d[c] = ST_FIRE;
                                wcnt_d[c]  = width_eff_s[c];
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] + CNT_ONE;
                        end
                    end
                    ST_FIRE: begin
                        if (wcnt_q[c] <= CNT_ONE) begin
                            state_d[c] = ST_COUNT;
                            cnt_d[c]   = CNT_ZERO;
                        end else begin
                            wcnt_d[c] = wcnt_q[c] - CNT_ONE;
                        end
                    end
                    ST_HOLD: begin
                        // Acknowledge beats a coincident overrun.
                        if (ack_i[c]) begin
                            state_d[c] = ST_COUNT;
                            cnt_d[c]   = CNT_ZERO;
                            ovf_d[c]   = OVF_ZERO;
                        end else if (match_s[c]) begin
                            cnt_d[c] = CNT_ZERO;
                            if (ovf_q[c] != OVF_MAX) begin
                                ovf_d[c] = ovf_q[c] + OVF_ONE;
                            end else begin
                                ovf_d[c] = OVF_MAX;
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[c] = ST_OFF;
                        cnt_d[c]   = CNT_ZERO;
                        ovf_d[c]   = OVF_ZERO;
                    end
                endcase
            end
            irq_d[c] = (state_d[c] == ST_FIRE) || (state_d[c] == ST_HOLD);
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= ST_OFF;
                cnt_q[c]   <= CNT_ZERO;
                wcnt_q[c]  <= CNT_ZERO;
                ovf_q[c]   <= OVF_ZERO;
            end
            irq_q <= {N_CH{1'b0}};
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                wcnt_q[c]  <= wcnt_d[c];
                ovf_q[c]   <= ovf_d[c];
            end
            irq_q <= irq_d;
        end
    end

`ifdef IRQ_STIM_JITTER_EN
    // LFSR next value: step only on period completions.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            lfsr_d[c] = lfsr_q[c];
            if (adv_s[c]) begin
                lfsr_d[c] = lfsr_step(lfsr_q[c]);
            end else begin
                lfsr_d[c] = lfsr_q[c];
            end
        end
    end

    // LFSR registers, seeded differently per channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                lfsr_q[c] <= 16'hACE1 ^ 16'(c);
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                lfsr_q[c] <= lfsr_d[c];
            end
        end
    end
`endif

endmodule

// File: tb/tb_irq_stim_gen.sv
// Directed self-checking bench for irq_stim_gen (N_CH=3, CNT_W=16, OVF_W=4).
module tb_irq_stim_gen;

    localparam int N_CH  = 3;
    localparam int CNT_W = 16;
    localparam int OVF_W = 4;

    logic                  clk_s = 1'b0;
    logic                  rst_s;
    logic [N_CH-1:0]       en_s;
    logic [N_CH-1:0]       mode_s;
    logic [N_CH*CNT_W-1:0] period_s;
    logic [N_CH*CNT_W-1:0] width_s;
    logic [N_CH-1:0]       ack_s;
    logic [N_CH-1:0]       irq_s;
    logic [N_CH*OVF_W-1:0] ovf_s;

    int n_checks = 0;
    int n_errors = 0;

    irq_stim_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .OVF_W(OVF_W), .JIT_MASK(16'h000F)) dut (
        .clk          (clk_s),
        .rst          (rst_s),
        .en_i         (en_s),
        .cfg_mode_i   (mode_s),
        .cfg_period_i (period_s),
        .cfg_width_i  (width_s),
        .ack_i        (ack_s),
        .irq_o        (irq_s),
        .ovf_cnt_o    (ovf_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then stable and inputs may be changed.
    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [15:0] per, input logic [15:0] wid,
                          input logic md);
        period_s[c*CNT_W +: CNT_W] = per;
        width_s[c*CNT_W +: CNT_W]  = wid;
        mode_s[c]                  = md;
    endtask

    task automatic do_reset();
        rst_s    = 1'b1;
        en_s     = 3'b000;
        ack_s    = 3'b000;
        mode_s   = 3'b000;
        period_s = '0;
        width_s  = '0;
        tick();
        tick();
        rst_s = 1'b0;
    endtask

    // Pulse-mode reference: edge k counted from the enable-sampling edge (k=0).
    function automatic logic exp_pulse(input int k, input int p, input int w);
        if (k < p) return 1'b0;
        return ((k - p) % (p + w)) < w;
    endfunction

    initial begin
        // 1. reset with all enables high
        rst_s = 1'b1; ack_s = 3'b000; mode_s = 3'b000; period_s = '0; width_s = '0;
        en_s  = 3'b111;
        set_ch(0, 16'd5, 16'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_rst_irq", 32'(irq_s), 32'd0);
            chk("t1_rst_ovf", 32'(ovf_s), 32'd0);
        end
        rst_s = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick();
            chk("t1_ch0_latency", 32'(irq_s[0]), 32'(exp_pulse(k, 5, 2)));
        end

        // 2. pulse mode, ch1 period 4 width 3, then width 0
        do_reset();
        set_ch(1, 16'd4, 16'd3, 1'b0);
        en_s = 3'b010;
        for (int k = 0; k < 4 + 70; k++) begin
            tick();
            chk("t2_pulse_w3", 32'(irq_s), 32'({1'b0, exp_pulse(k, 4, 3), 1'b0}));
        end
        do_reset();
        set_ch(1, 16'd4, 16'd0, 1'b0);
        en_s = 3'b010;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("t2_pulse_w0", 32'(irq_s[1]), 32'(exp_pulse(k, 4, 1)));
        end

        // 2b. acks in COUNT/FIRE of a pulse channel are ignored
        do_reset();
        set_ch(1, 16'd4, 16'd3, 1'b0);
        en_s  = 3'b010;
        ack_s = 3'b010;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t2b_stray_ack", 32'(irq_s[1]), 32'(exp_pulse(k, 4, 3)));
        end
        ack_s = 3'b000;

        // 3. level mode, ch2 period 8, overruns and saturation
        do_reset();
        set_ch(2, 16'd8, 16'd1, 1'b1);
        en_s = 3'b100;
        for (int k = 0; k <= 140; k++) begin
            tick();
            chk("t3_level_irq", 32'(irq_s[2]), 32'(k >= 8));
            if (k == 39)  chk("t3_ovf_39",  32'(ovf_s[11:8]), 32'd3);
            if (k == 40)  chk("t3_ovf_40",  32'(ovf_s[11:8]), 32'd4);
            if (k == 127) chk("t3_ovf_127", 32'(ovf_s[11:8]), 32'd14);
            if (k == 128) chk("t3_ovf_128", 32'(ovf_s[11:8]), 32'd15);
            if (k == 140) chk("t3_ovf_sat", 32'(ovf_s[11:8]), 32'd15);
        end
        ack_s = 3'b100;
        tick();                                   // k = 141
        ack_s = 3'b000;
        chk("t3_ack_irq", 32'(irq_s[2]), 32'd0);
        chk("t3_ack_ovf", 32'(ovf_s[11:8]), 32'd0);
        for (int k = 142; k <= 149; k++) begin
            tick();
            chk("t3_rerise", 32'(irq_s[2]), 32'(k == 149));
        end

        // 4. ack on the overrun edge (157), stray ack in COUNT (160)
        for (int k = 150; k <= 165; k++) begin
            tick();
            chk("t4_ack_ovr_irq", 32'(irq_s[2]), 32'((k < 157) || (k == 165)));
            chk("t4_ack_ovr_ovf", 32'(ovf_s[11:8]), 32'd0);
            ack_s = ((k == 156) || (k == 159)) ? 3'b100 : 3'b000;
        end
        ack_s = 3'b000;

        // 5. disable during FIRE, re-enable, period 0 while enabled
        do_reset();
        set_ch(0, 16'd5, 16'd3, 1'b0);
        en_s = 3'b001;
        for (int k = 0; k <= 5; k++) begin
            tick();
            chk("t5_first", 32'(irq_s[0]), 32'(k == 5));
        end
        en_s = 3'b000;
        tick();
        chk("t5_dis_fire", 32'(irq_s[0]), 32'd0);
        tick();
        chk("t5_dis_hold", 32'(irq_s[0]), 32'd0);
        set_ch(0, 16'd3, 16'd3, 1'b0);
        en_s = 3'b001;
        for (int k = 8; k <= 11; k++) begin
            tick();
            chk("t5_reen", 32'(irq_s[0]), 32'(k == 11));
        end
        set_ch(0, 16'd0, 16'd3, 1'b0);
        tick();
        chk("t5_per0_a", 32'(irq_s[0]), 32'd0);
        tick();
        chk("t5_per0_b", 32'(irq_s[0]), 32'd0);

        // 6. independence: periods 3/5/7, width 1, 500 cycles
        do_reset();
        set_ch(0, 16'd3, 16'd1, 1'b0);
        set_ch(1, 16'd5, 16'd1, 1'b0);
        set_ch(2, 16'd7, 16'd1, 1'b0);
        en_s = 3'b111;
        begin
            int per[3];
            int last_rise[3];
            logic [N_CH-1:0] prev;
            per[0] = 3; per[1] = 5; per[2] = 7;
            last_rise[0] = -1; last_rise[1] = -1; last_rise[2] = -1;
            prev = 3'b000;
            for (int k = 0; k < 500; k++) begin
                tick();
                for (int c = 0; c < N_CH; c++) begin
`ifdef IRQ_STIM_JITTER_EN
                    if (irq_s[c] && !prev[c]) begin
                        if (last_rise[c] >= 0)
                            chk("t6_jit_gap",
                                32'(((k - last_rise[c]) >= per[c] + 1) &&
                                    ((k - last_rise[c]) <= per[c] + 16)), 32'd1);
                        last_rise[c] = k;
                    end
`else
                    chk("t6_indep", 32'(irq_s[c]), 32'(exp_pulse(k, per[c], 1)));
`endif
                end
                prev = irq_s;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
